// File: rtl/seq_fsm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared types, defaults and helpers for the seq_fsm_multi
//            start/progress/release sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Per-channel sequencer state; ST_ERR is reachable only with SEQ_TIMEOUT_EN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_ERR  = 2'b11
  } seq_state_t;

  // Default width of each run-cycle counter.
  localparam int SEQ_CNT_W_DEFAULT = 8;

  // Saturating increment for a value of width w (w <= 63); never wraps.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_fsm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : seq_ch
// Purpose  : One sequencer channel: IDLE -> RUN -> HOLD -> IDLE handshake,
//            RUN-phase cycle counter, run_cycles capture and done pulse.
//            Optional RUN timeout into ERR when SEQ_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ch
  import seq_pkg::*;
#(
  parameter int CNT_W   = SEQ_CNT_W_DEFAULT,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             p,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] run_cycles
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = CNT_W'(sat_inc(64'(cnt_q), CNT_W));

  // Next-state, counter and capture logic; done is only raised on HOLD exit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!p) begin
          state_d      = ST_HOLD;
          run_cycles_d = cnt_inc;
`ifdef SEQ_TIMEOUT_EN
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d      = ST_ERR;
          run_cycles_d = CNT_W'(TIMEOUT);
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      ST_ERR: begin
        if (!s) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers, cleared asynchronously so no done survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
    end
  end

  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign run_cycles = run_cycles_q;
`ifdef SEQ_TIMEOUT_EN
  assign err        = (state_q == ST_ERR);
`else
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/seq_fsm_multi.sv
`default_nettype none
// ============================================================================
// Module   : seq_fsm_multi
// Purpose  : N_CH independent start/progress/release sequencers with per
//            channel RUN-length measurement and a global all_idle flag.
//            Optional timeout compiled in with macro SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_fsm_multi
  import seq_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = SEQ_CNT_W_DEFAULT,
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       s,
  input  logic [N_CH-1:0]       p,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       err,
  output logic [N_CH*CNT_W-1:0] run_cycles,
  output logic                  all_idle
);

  // One fully independent channel per bit of s/p.
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      seq_ch #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .s         (s[i]),
        .p         (p[i]),
        .done      (done[i]),
        .busy      (busy[i]),
        .err       (err[i]),
        .run_cycles(run_cycles[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign all_idle = ~|busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_fsm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_fsm_multi
// Purpose  : Self-checking bench for seq_fsm_multi (directed steps, done
//            pulses checked against a queue of expected run lengths).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_fsm_multi;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int WB = 3;
  localparam int TO = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   s   = '0;
  logic [N-1:0]   p   = '0;
  logic [N-1:0]   done_a, busy_a, err_a;
  logic [N*W-1:0] rc_a;
  logic           all_idle_a;

  logic [0:0]     s_b = '0;
  logic [0:0]     p_b = '0;
  logic [0:0]     done_b, busy_b, err_b;
  logic [WB-1:0]  rc_b;
  logic           all_idle_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    logic [W-1:0] rc;
  } exp_t;
  exp_t exp_q[$];

  seq_fsm_multi #(.N_CH(N), .CNT_W(W), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .s(s), .p(p), .done(done_a), .busy(busy_a),
    .err(err_a), .run_cycles(rc_a), .all_idle(all_idle_a)
  );

  seq_fsm_multi #(.N_CH(1), .CNT_W(WB), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .s(s_b), .p(p_b), .done(done_b), .busy(busy_b),
    .err(err_b), .run_cycles(rc_b), .all_idle(all_idle_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rc(input int ch);
    return rc_a[ch*W +: W];
  endfunction

  task automatic push(input int ch, input logic [W-1:0] v);
    exp_t e;
    e.ch = ch;
    e.rc = v;
    exp_q.push_back(e);
  endtask

  // Every done pulse on dut_a must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (done_a[i]) begin
          total++;
          assert (exp_q.size() > 0)
          else begin
            bad++;
            $error("FAIL unexpected_done ch=%0d observed=1 expected=0", i);
          end
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            assert (e.ch === i && rc_a[i*W +: W] === e.rc)
            else begin
              bad++;
              $error("FAIL sb_done observed ch=%0d rc=%0d expected ch=%0d rc=%0d",
                     i, rc_a[i*W +: W], e.ch, e.rc);
            end
          end
        end
      end
    end
  end

  initial begin
    // ---- 1. reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s   = N'($urandom_range(0, 15));
      p   = N'($urandom_range(0, 15));
      s_b = 1'($urandom_range(0, 1));
      p_b = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_rc", 64'(rc_a), 64'd0);
    chk("rst_all_idle", 64'(all_idle_a), 64'd1);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    s = '0; p = '0; s_b = '0; p_b = '0;
    rst = 1'b0;
    tick();

    // ---- 2. nominal completion on ch0
    s[0] = 1'b1; p[0] = 1'b1;
    tick();
    chk("nom_run", 64'(busy_a), 64'h1);
    chk("nom_all_idle", 64'(all_idle_a), 64'd0);
    tick(); tick(); tick();
    chk("nom_still_run", 64'(busy_a), 64'h1);
    p[0] = 1'b0;
    push(0, 8'd4);
    tick();
    chk("nom_rc", 64'(rc(0)), 64'd4);
    tick(); tick();
    chk("nom_hold_nodone", 64'(done_a), 64'd0);
    chk("nom_hold_busy", 64'(busy_a), 64'h1);
    s[0] = 1'b0;
    tick();
    chk("nom_done", 64'(done_a), 64'h1);
    chk("nom_idle", 64'(busy_a), 64'h0);
    tick();
    chk("nom_done_1cyc", 64'(done_a), 64'h0);
    chk("nom_rc_hold", 64'(rc(0)), 64'd4);
    chk("nom_others_rc", 64'(rc_a[N*W-1:W]), 64'd0);

    // ---- 4. simultaneous start/progress, then restart on done cycle (ch1)
    s[1] = 1'b1; p[1] = 1'b0;
    tick();
    chk("sim_run", 64'(busy_a), 64'h2);
    push(1, 8'd1);
    tick();
    chk("sim_rc", 64'(rc(1)), 64'd1);
    s[1] = 1'b0;
    tick();
    chk("sim_done", 64'(done_a), 64'h2);
    s[1] = 1'b1; p[1] = 1'b1;
    tick();
    chk("sim_reenter", 64'(busy_a), 64'h2);
    chk("sim_reenter_nodone", 64'(done_a), 64'h0);
    chk("sim_rc_kept", 64'(rc(1)), 64'd1);
    tick(); tick();
    p[1] = 1'b0;
    push(1, 8'd3);
    tick();
    chk("sim_rc2", 64'(rc(1)), 64'd3);
    s[1] = 1'b0;
    tick();
    chk("sim_done2", 64'(done_a), 64'h2);
    tick();

`ifndef SEQ_TIMEOUT_EN
    // ---- 3. saturation on 3-bit counter
    s_b = 1'b1; p_b = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) tick();
    chk("sat_busy", 64'(busy_b), 64'd1);
    p_b = 1'b0;
    tick();
    chk("sat_rc", 64'(rc_b), 64'd7);
    s_b = 1'b0;
    tick();
    chk("sat_done", 64'(done_b), 64'd1);
    chk("sat_idle", 64'(all_idle_b), 64'd1);
    tick();
`else
    // ---- 5. timeout on ch2, then p=0 on the limit cycle wins
    s[2] = 1'b1; p[2] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("to_pre_err", 64'(err_a), 64'd0);
    tick();
    chk("to_err", 64'(err_a), 64'h4);
    chk("to_busy", 64'(busy_a), 64'h4);
    chk("to_rc", 64'(rc(2)), 64'd5);
    s[2] = 1'b0;
    tick();
    chk("to_idle", 64'(busy_a), 64'h0);
    chk("to_err_clr", 64'(err_a), 64'h0);
    chk("to_nodone", 64'(done_a), 64'h0);
    tick();
    s[2] = 1'b1; p[2] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    p[2] = 1'b0;
    push(2, 8'd5);
    tick();
    chk("to_prio_err", 64'(err_a), 64'd0);
    chk("to_prio_rc", 64'(rc(2)), 64'd5);
    s[2] = 1'b0;
    tick();
    chk("to_prio_done", 64'(done_a), 64'h4);
    tick();
`endif

    // ---- 6. reset mid-operation, then independent ch2 run
    s = 4'b0011; p = 4'b0010;
    tick();
    tick();
    chk("mid_busy_pre", 64'(busy_a), 64'h3);
    #3 rst = 1'b1;
    #1;
    chk("mid_busy", 64'(busy_a), 64'h0);
    chk("mid_rc", 64'(rc_a), 64'd0);
    chk("mid_done", 64'(done_a), 64'h0);
    chk("mid_all_idle", 64'(all_idle_a), 64'd1);
    s = '0; p = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_done", 64'(done_a), 64'h0);
    s[2] = 1'b1; p[2] = 1'b1;
    tick();
    chk("ind_busy", 64'(busy_a), 64'h4);
    tick();
    p[2] = 1'b0;
    push(2, 8'd2);
    tick();
    chk("ind_rc", 64'(rc(2)), 64'd2);
    chk("ind_others_rc", 64'({rc(3), rc(1), rc(0)}), 64'd0);
    s[2] = 1'b0;
    tick();
    chk("ind_done", 64'(done_a), 64'h4);
    tick();
    chk("ind_all_idle", 64'(all_idle_a), 64'd1);

    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
